mtime_master: RTL and testbench

MTIME_MASTER -- requirements
Module: mtime_master

---
 rtl/mtime_pkg.sv | 41 ++++
 rtl/mtime_master_if.sv | 41 ++++
 rtl/mtime_master.sv | 222 ++++++++++++++++++++++
 tb/tb_mtime_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtime_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mtime_pkg
// Purpose : Shared definitions for the mtime_master timer-access engine.
//           Holds the timer word map, the command opcode encoding and the
//           controller state enumeration.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mtime_pkg;

  // Word addresses of the 64-bit timer as seen over the 32-bit Avalon-MM bus
  localparam logic [1:0] ADDR_COUNT_LO = 2'd0;
  localparam logic [1:0] ADDR_COUNT_HI = 2'd1;
  localparam logic [1:0] ADDR_CMP_LO   = 2'd2;
  localparam logic [1:0] ADDR_CMP_HI   = 2'd3;

  // Parking value for the compare high word while the low word changes
  localparam logic [31:0] CMP_PARK_HI = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_READ_COUNT  = 2'd0,
    OP_WRITE_CMP   = 2'd1,
    OP_WRITE_COUNT = 2'd2,
    OP_RESERVED    = 2'd3
  } cmd_op_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_HI1 = 4'd1,
    RD_LO  = 4'd2,
    RD_HI2 = 4'd3,
    RWAIT  = 4'd4,
    WR0    = 4'd5,
    WR1    = 4'd6,
    WR2    = 4'd7,
    RESP   = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mtime_master_if.sv
`default_nettype none
// ============================================================================
// Module  : mtime_master_if
// Purpose : Bundles the command/response handshake and the Avalon-MM
//           initiator signals of mtime_master.
// Ports   : cmd_valid/cmd_ready/cmd_op/cmd_data  - command channel
//           rsp_valid/rsp_data                   - completion pulse + result
//           m_addr/m_read/m_write/m_writedata    - Avalon-MM request
//           m_readdata/m_waitrequest             - Avalon-MM return
//           modport master : the mtime_master side
//           modport slave  : the command issuer / timer side
// Revision: 1.0 - initial release
// ============================================================================
interface mtime_master_if;
  import mtime_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [1:0]  m_addr;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, m_readdata, m_waitrequest,
    output cmd_ready, rsp_valid, rsp_data, m_addr, m_read, m_write, m_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, m_readdata, m_waitrequest,
    input  cmd_ready, rsp_valid, rsp_data, m_addr, m_read, m_write, m_writedata
  );

endinterface
`default_nettype wire

// File: rtl/mtime_master.sv
`default_nettype none
// ============================================================================
// Module  : mtime_master
// Purpose : Converts 64-bit timer commands (read count, write compare,
//           write count) into tear-free sequences of 32-bit Avalon-MM
//           transfers against the timer word map.
// Ports   : clk    - sole clock, rising edge
//           rst_n  - synchronous active-low reset
//           bus    - mtime_master_if.master (command, response, Avalon-MM)
// Params  : READ_LATENCY - cycles from read acceptance to valid m_readdata
//                          (must be >= 1)
// Revision: 1.0 - initial release
// ============================================================================
module mtime_master
  import mtime_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mtime_master_if.master bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t            r_state, w_state;
  state_t            r_ret_state, w_ret_state;   // read phase that owns RWAIT
  cmd_op_t           r_op, w_op;
  logic [63:0]       r_data, w_data;
  logic [31:0]       r_hi1, w_hi1;
  logic [31:0]       r_lo, w_lo;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [1:0]        r_m_addr, w_m_addr;
  logic              r_m_read, w_m_read;
  logic              r_m_write, w_m_write;
  logic [31:0]       r_m_wdata, w_m_wdata;
  logic [63:0]       r_rsp_data, w_rsp_data;
  logic              r_alive;                    // low until first edge out of reset
  logic              w_cmd_ready;
  logic              w_acc;

  assign w_cmd_ready = (r_state == IDLE) && r_alive;
  assign w_acc       = (r_m_read | r_m_write) & ~bus.m_waitrequest;

  always_comb begin
    w_state     = r_state;
    w_ret_state = r_ret_state;
    w_op        = r_op;
    w_data      = r_data;
    w_hi1       = r_hi1;
    w_lo        = r_lo;
    w_cnt       = r_cnt;
    w_m_addr    = r_m_addr;
    w_m_read    = r_m_read;
    w_m_write   = r_m_write;
    w_m_wdata   = r_m_wdata;
    w_rsp_data  = r_rsp_data;

    case (r_state)
      IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          w_data = bus.cmd_data;
          case (cmd_op_t'(bus.cmd_op))
            OP_WRITE_CMP: begin
              // Park compare-hi at all-ones so the half-updated value cannot match
              w_op      = OP_WRITE_CMP;
              w_m_write = 1'b1;
              w_m_addr  = ADDR_CMP_HI;
              w_m_wdata = CMP_PARK_HI;
              w_state   = WR0;
            end
            OP_WRITE_COUNT: begin
              // Clear count-lo first so no carry ripples into the new hi word
              w_op      = OP_WRITE_COUNT;
              w_m_write = 1'b1;
              w_m_addr  = ADDR_COUNT_LO;
              w_m_wdata = 32'd0;
              w_state   = WR0;
            end
            default: begin
              // Reserved opcode behaves as a count read; the read sequence
              // opens with an issue slot in RD_HI1 before its first strobe.
              w_op    = OP_READ_COUNT;
              w_state = RD_HI1;
            end
          endcase
        end
      end

      RD_HI1, RD_LO, RD_HI2: begin
        if (!r_m_read) begin
          w_m_read = 1'b1;
          w_m_addr = (r_state == RD_LO) ? ADDR_COUNT_LO : ADDR_COUNT_HI;
        end else if (w_acc) begin
          w_m_read    = 1'b0;
          w_cnt       = CNT_LOAD;
          w_ret_state = r_state;
          w_state     = RWAIT;
        end
      end

      RWAIT: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          // Sample the returning word and launch the next read in the same edge
          case (r_ret_state)
            RD_HI1: begin
              w_hi1    = bus.m_readdata;
              w_m_read = 1'b1;
              w_m_addr = ADDR_COUNT_LO;
              w_state  = RD_LO;
            end
            RD_LO: begin
              w_lo     = bus.m_readdata;
              w_m_read = 1'b1;
              w_m_addr = ADDR_COUNT_HI;
              w_state  = RD_HI2;
            end
            default: begin
              if (bus.m_readdata == r_hi1) begin
                w_rsp_data = {r_hi1, r_lo};
                w_state    = RESP;
              end else begin
                // Carry crossed between reads: adopt the new hi, re-read lo
                w_hi1    = bus.m_readdata;
                w_m_read = 1'b1;
                w_m_addr = ADDR_COUNT_LO;
                w_state  = RD_LO;
              end
            end
          endcase
        end
      end

      WR0: begin
        if (w_acc) begin
          w_state = WR1;
          if (r_op == OP_WRITE_CMP) begin
            w_m_addr  = ADDR_CMP_LO;
            w_m_wdata = r_data[31:0];
          end else begin
            w_m_addr  = ADDR_COUNT_HI;
            w_m_wdata = r_data[63:32];
          end
        end
      end

      WR1: begin
        if (w_acc) begin
          w_state = WR2;
          if (r_op == OP_WRITE_CMP) begin
            w_m_addr  = ADDR_CMP_HI;
            w_m_wdata = r_data[63:32];
          end else begin
            w_m_addr  = ADDR_COUNT_LO;
            w_m_wdata = r_data[31:0];
          end
        end
      end

      WR2: begin
        if (w_acc) begin
          w_m_write  = 1'b0;
          w_rsp_data = 64'd0;
          w_state    = RESP;
        end
      end

      RESP: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ret_state <= IDLE;
      r_op        <= OP_READ_COUNT;
      r_data      <= 64'd0;
      r_hi1       <= 32'd0;
      r_lo        <= 32'd0;
      r_cnt       <= '0;
      r_m_addr    <= 2'd0;
      r_m_read    <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_wdata   <= 32'd0;
      r_rsp_data  <= 64'd0;
      r_alive     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_ret_state <= w_ret_state;
      r_op        <= w_op;
      r_data      <= w_data;
      r_hi1       <= w_hi1;
      r_lo        <= w_lo;
      r_cnt       <= w_cnt;
      r_m_addr    <= w_m_addr;
      r_m_read    <= w_m_read;
      r_m_write   <= w_m_write;
      r_m_wdata   <= w_m_wdata;
      r_rsp_data  <= w_rsp_data;
      r_alive     <= 1'b1;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.rsp_valid   = (r_state == RESP);
  assign bus.rsp_data    = r_rsp_data;
  assign bus.m_addr      = r_m_addr;
  assign bus.m_read      = r_m_read;
  assign bus.m_write     = r_m_write;
  assign bus.m_writedata = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mtime_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_mtime_master
// Purpose : Directed self-checking bench for mtime_master. Contains a small
//           timer slave (count/compare words, programmable waitrequest
//           stall, one-cycle read latency) and a transfer log.
// Ports   : none (top-level bench)
// Revision: 1.0 - initial release
// ============================================================================
module tb_mtime_master;
  import mtime_pkg::*;

  logic clk;
  logic rst_n;

  mtime_master_if bus();

  mtime_master #(.READ_LATENCY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- timer slave model configuration ----------------
  logic [63:0] cfg_count, cfg_cmp, cfg_bump_val;
  logic        cfg_load, cfg_bump;
  int          cfg_stall;

  logic [63:0] tmr_count, tmr_cmp;
  logic        bumped;
  int          held;
  int          ovf_hits, stab_err, both_err, rsp_cnt;
  logic        stall_pend;
  logic [36:0] stall_snap;
  logic [34:0] log_q [$];        // {write, addr, data}
  logic [34:0] exp_log [5];

  int n_checks = 0;
  int n_errors = 0;

  assign bus.m_waitrequest = (bus.m_read | bus.m_write) && (held < cfg_stall);

  function automatic logic [31:0] word_of(input logic [1:0] a, input logic [63:0] c,
                                          input logic [63:0] m);
    case (a)
      2'd0:    return c[31:0];
      2'd1:    return c[63:32];
      2'd2:    return m[31:0];
      default: return m[63:32];
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (cfg_load) begin
      tmr_count  <= cfg_count;
      tmr_cmp    <= cfg_cmp;
      bumped     <= 1'b0;
      ovf_hits   <= 0;
      stab_err   <= 0;
      both_err   <= 0;
      held       <= 0;
      stall_pend <= 1'b0;
    end else begin
      if (tmr_count == tmr_cmp) ovf_hits <= ovf_hits + 1;
      if ((bus.m_read | bus.m_write) && bus.m_waitrequest) held <= held + 1;
      else held <= 0;
      if (rst_n) begin
        if (stall_pend &&
            ({bus.m_read, bus.m_write, bus.m_addr, bus.m_writedata} != stall_snap))
          stab_err <= stab_err + 1;
        stall_pend <= (bus.m_read | bus.m_write) && bus.m_waitrequest;
        stall_snap <= {bus.m_read, bus.m_write, bus.m_addr, bus.m_writedata};
        if (bus.m_read && bus.m_write) both_err <= both_err + 1;
        if (bus.m_read && !bus.m_waitrequest) begin
          bus.m_readdata <= word_of(bus.m_addr, tmr_count, tmr_cmp);
          log_q.push_back({1'b0, bus.m_addr, word_of(bus.m_addr, tmr_count, tmr_cmp)});
          if (cfg_bump && !bumped && bus.m_addr == 2'd1) begin
            tmr_count <= cfg_bump_val;
            bumped    <= 1'b1;
          end
        end
        if (bus.m_write && !bus.m_waitrequest) begin
          log_q.push_back({1'b1, bus.m_addr, bus.m_writedata});
          case (bus.m_addr)
            2'd0:    tmr_count[31:0]  <= bus.m_writedata;
            2'd1:    tmr_count[63:32] <= bus.m_writedata;
            2'd2:    tmr_cmp[31:0]    <= bus.m_writedata;
            default: tmr_cmp[63:32]   <= bus.m_writedata;
          endcase
        end
      end else begin
        stall_pend <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n);
    check_eq({tag, "_nxfer"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < log_q.size())
        check_eq($sformatf("%s_xfer%0d", tag, i), 64'(log_q[i]), 64'(exp_log[i]));
  endtask

  task automatic load(input logic [63:0] cnt, input logic [63:0] cmp);
    cfg_count = cnt;
    cfg_cmp   = cmp;
    cfg_load  = 1'b1;
    @(negedge clk);
    cfg_load  = 1'b0;
    log_q.delete();
  endtask

  // Issue one command from a negedge; returns the response and the number of
  // cycles from the accepting edge to the rsp_valid cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [63:0] data,
                        output logic [63:0] rsp, output int lat);
    int n;
    rsp = '0;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_arrives", 64'(bus.rsp_valid), 64'd1);
    rsp = bus.rsp_data;
    lat = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rsp;
    int          lat;
    int          n;
    int          rsp_before;

    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_data   = 64'd0;
    bus.m_readdata = 32'd0;
    cfg_stall      = 0;
    cfg_bump       = 1'b0;
    cfg_bump_val   = 64'd0;
    cfg_count      = 64'd0;
    cfg_cmp        = '1;
    cfg_load       = 1'b1;
    rsp_cnt        = 0;
    repeat (3) @(negedge clk);
    cfg_load = 1'b0;

    // ---- reset state ----
    check_eq("rst_cmd_ready",   64'(bus.cmd_ready),   64'd0);
    check_eq("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
    check_eq("rst_rsp_data",    bus.rsp_data,         64'd0);
    check_eq("rst_m_read",      64'(bus.m_read),      64'd0);
    check_eq("rst_m_write",     64'(bus.m_write),     64'd0);
    check_eq("rst_m_addr",      64'(bus.m_addr),      64'd0);
    check_eq("rst_m_writedata", 64'(bus.m_writedata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // ---- read count, frozen timer ----
    load(64'h0000_0005_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF);
    do_cmd(OP_READ_COUNT, 64'd0, rsp, lat);
    check_eq("rd_data", rsp, 64'h0000_0005_1234_5678);
    check_eq("rd_latency", 64'(lat), 64'd8);
    exp_log[0] = {1'b0, 2'd1, 32'h0000_0005};
    exp_log[1] = {1'b0, 2'd0, 32'h1234_5678};
    exp_log[2] = {1'b0, 2'd1, 32'h0000_0005};
    check_log("rd", 3);
    @(negedge clk);
    check_eq("rd_rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);
    check_eq("rd_rsp_hold", bus.rsp_data, 64'h0000_0005_1234_5678);
    check_eq("rd_ready_after", 64'(bus.cmd_ready), 64'd1);

    // ---- read count with carry between hi reads ----
    cfg_bump     = 1'b1;
    cfg_bump_val = 64'h0000_0006_0000_0002;
    load(64'h0000_0005_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_cmd(OP_READ_COUNT, 64'd0, rsp, lat);
    cfg_bump = 1'b0;
    check_eq("carry_data", rsp, 64'h0000_0006_0000_0002);
    check_eq("carry_latency", 64'(lat), 64'd12);
    exp_log[0] = {1'b0, 2'd1, 32'h0000_0005};
    exp_log[1] = {1'b0, 2'd0, 32'h0000_0002};
    exp_log[2] = {1'b0, 2'd1, 32'h0000_0006};
    exp_log[3] = {1'b0, 2'd0, 32'h0000_0002};
    exp_log[4] = {1'b0, 2'd1, 32'h0000_0006};
    check_log("carry", 5);

    // ---- write compare, no transient match ----
    load(64'h0000_0000_0000_0010, 64'h0000_0000_FFFF_FFFF);
    do_cmd(OP_WRITE_CMP, 64'h0000_0001_0000_0010, rsp, lat);
    @(negedge clk);
    check_eq("wcmp_rsp_data", rsp, 64'd0);
    check_eq("wcmp_latency", 64'(lat), 64'd4);
    exp_log[0] = {1'b1, 2'd3, 32'hFFFF_FFFF};
    exp_log[1] = {1'b1, 2'd2, 32'h0000_0010};
    exp_log[2] = {1'b1, 2'd3, 32'h0000_0001};
    check_log("wcmp", 3);
    check_eq("wcmp_no_overflow", 64'(ovf_hits), 64'd0);
    check_eq("wcmp_final_cmp", tmr_cmp, 64'h0000_0001_0000_0010);

    // ---- write count with 3-cycle waitrequest per transfer ----
    load(64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    cfg_stall  = 3;
    rsp_before = rsp_cnt;
    do_cmd(OP_WRITE_COUNT, 64'h0000_0002_FFFF_FFF0, rsp, lat);
    repeat (3) @(negedge clk);
    cfg_stall = 0;
    check_eq("wcnt_latency", 64'(lat), 64'd13);
    exp_log[0] = {1'b1, 2'd0, 32'h0000_0000};
    exp_log[1] = {1'b1, 2'd1, 32'h0000_0002};
    exp_log[2] = {1'b1, 2'd0, 32'hFFFF_FFF0};
    check_log("wcnt", 3);
    check_eq("wcnt_stable", 64'(stab_err), 64'd0);
    check_eq("wcnt_one_rsp", 64'(rsp_cnt - rsp_before), 64'd1);
    check_eq("wcnt_final_count", tmr_count, 64'h0000_0002_FFFF_FFF0);

    // ---- reserved opcode reads the count back ----
    log_q.delete();
    do_cmd(OP_RESERVED, 64'hDEAD_BEEF_DEAD_BEEF, rsp, lat);
    check_eq("rsvd_data", rsp, 64'h0000_0002_FFFF_FFF0);
    check_eq("rsvd_latency", 64'(lat), 64'd8);
    check_eq("rw_never_both", 64'(both_err), 64'd0);

    // ---- reset during a stalled RD_LO ----
    @(negedge clk);
    load(64'h0000_0005_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.cmd_op    = OP_READ_COUNT;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.m_read && bus.m_addr == 2'd0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reach_rd_lo", 64'(bus.m_read && bus.m_addr == 2'd0), 64'd1);
    cfg_stall  = 1000;
    rsp_before = rsp_cnt;
    @(negedge clk);
    check_eq("abort_stalled_read", 64'(bus.m_read), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_m_read", 64'(bus.m_read), 64'd0);
    check_eq("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    cfg_stall = 0;
    rst_n     = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_after", 64'(bus.cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    check_eq("abort_no_rsp", 64'(rsp_cnt - rsp_before), 64'd0);
    do_cmd(OP_READ_COUNT, 64'd0, rsp, lat);
    check_eq("abort_recover_data", rsp, 64'h0000_0005_1234_5678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
